// File: rtl/mdu_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: issue/operand signals from the
// pipeline, busy/read-data/architectural HI-LO back from the unit.
interface mdu_unit_if;
   logic        Req;
   logic        Start;
   logic [3:0]  MDUOP;
   logic [1:0]  ReadHILO;
   logic [31:0] RD1;
   logic [31:0] RD2;
   logic        Busy;
   logic [31:0] MDUResult;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Req, Start, MDUOP, ReadHILO, RD1, RD2,
      input  Busy, MDUResult, HI, LO
   );

   modport slave (
      input  Req, Start, MDUOP, ReadHILO, RD1, RD2,
      output Busy, MDUResult, HI, LO
   );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO. The result is computed at
// issue and held in pending registers until the latency counter expires.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       rst,
   mdu_unit_if.slave bus
);

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic        busy_q;
   logic [3:0]  cnt_q;
   logic [3:0]  op_q;
   logic        dz_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] hi_p_q, lo_p_q;

   logic        is_arith, is_div, issue, mt_wr;
   logic [31:0] hi_p_d, lo_p_d;
   logic [63:0] prod_s, prod_u;
   logic        sa, sb;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

   assign is_arith = (bus.MDUOP >= OP_MULT) && (bus.MDUOP <= OP_DIVU);
   assign is_div   = (bus.MDUOP == OP_DIV) || (bus.MDUOP == OP_DIVU);
   assign issue    = bus.Start && is_arith && !busy_q && !bus.Req;
   assign mt_wr    = !bus.Req && !busy_q &&
                     ((bus.MDUOP == OP_MTHI) || (bus.MDUOP == OP_MTLO));

   // Two's-complement low 64 bits of the sign-extended product equal the signed product.
   assign prod_s = {{32{bus.RD1[31]}}, bus.RD1} * {{32{bus.RD2[31]}}, bus.RD2};
   assign prod_u = {32'd0, bus.RD1} * {32'd0, bus.RD2};

   // Signed divide runs on magnitudes so INT_MIN / -1 and /0 never hit a native signed divide.
   assign sa     = (bus.MDUOP == OP_DIV) && bus.RD1[31];
   assign sb     = (bus.MDUOP == OP_DIV) && bus.RD2[31];
   assign a_mag  = sa ? (~bus.RD1 + 32'd1) : bus.RD1;
   assign b_mag  = sb ? (~bus.RD2 + 32'd1) : bus.RD2;
   assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;

   always_comb begin
      hi_p_d = 32'd0;
      lo_p_d = 32'd0;
      case (bus.MDUOP)
         OP_MULT: begin
            hi_p_d = prod_s[63:32];
            lo_p_d = prod_s[31:0];
         end
         OP_MULTU: begin
            hi_p_d = prod_u[63:32];
            lo_p_d = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            lo_p_d = (sa ^ sb) ? (~q_mag + 32'd1) : q_mag;
            hi_p_d = sa ? (~r_mag + 32'd1) : r_mag;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= 4'd0;
         op_q    <= OP_NONE;
         dz_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hi_p_q  <= 32'd0;
         lo_p_q  <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue) begin
                  hi_p_q  <= hi_p_d;
                  lo_p_q  <= lo_p_d;
                  op_q    <= bus.MDUOP;
                  dz_q    <= is_div && (bus.RD2 == 32'd0);
                  cnt_q   <= is_div ? DIV_N : MULT_N;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else if (mt_wr) begin
                  if (bus.MDUOP == OP_MTHI) hi_q <= bus.RD1;
                  else                      lo_q <= bus.RD1;
               end
            end
            RUN: begin
               if (cnt_q <= 4'd1) begin
                  // A divide by zero retires without touching HI/LO.
                  if (!(dz_q && ((op_q == OP_DIV) || (op_q == OP_DIVU)))) begin
                     hi_q <= hi_p_q;
                     lo_q <= lo_p_q;
                  end
                  cnt_q   <= 4'd0;
                  op_q    <= OP_NONE;
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.HI        = hi_q;
   assign bus.LO        = lo_q;
   assign bus.MDUResult = (bus.ReadHILO == 2'd1) ? hi_q :
                          (bus.ReadHILO == 2'd2) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a vector table of MULT/DIV results and latencies,
// then hand-written reset, Req, busy-issue and back-to-back sequences.
module tb_mdu_unit;

   logic clk;
   logic rst;
   mdu_unit_if bus();

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
   } vec_t;

   vec_t vecs[10];
   int   n_checks;
   int   n_fail;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.Start    = 1'b0;
      bus.MDUOP    = 4'd0;
      bus.Req      = 1'b0;
      bus.RD1      = 32'd0;
      bus.RD2      = 32'd0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start = 1'b1;
      bus.MDUOP = op;
      bus.RD1   = a;
      bus.RD2   = b;
      tick();
      bus.Start = 1'b0;
      bus.MDUOP = 4'd0;
   endtask

   // Counts Busy cycles from the current one; also returns LO read in the last busy cycle.
   task automatic wait_idle(output int cnt, output logic [31:0] last_lo);
      cnt = 0;
      last_lo = 32'd0;
      bus.ReadHILO = 2'd2;
      while (bus.Busy === 1'b1 && cnt < 40) begin
         cnt++;
         last_lo = bus.MDUResult;
         tick();
      end
   endtask

   initial begin
      int          cnt;
      logic [31:0] lo_last;
      logic [31:0] hi_save, lo_save;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
      vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3] = '{4'd4, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10};
      vecs[4] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[5] = '{4'd4, 32'd7,         32'd0,        32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[6] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vecs[7] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
      vecs[8] = '{4'd3, 32'd100,       32'd0,        32'h4000_0000, 32'h0000_0000, 10};
      vecs[9] = '{4'd1, 32'd3,         32'd4,        32'h0000_0000, 32'h0000_000C, 5};

      idle_inputs();
      bus.ReadHILO = 2'd0;
      rst = 1'b1;
      tick();
      tick();
      check("reset_busy", {31'd0, bus.Busy}, 32'd0);
      check("reset_hi", bus.HI, 32'd0);
      check("reset_lo", bus.LO, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].rd1, vecs[i].rd2);
         wait_idle(cnt, lo_last);
         check($sformatf("vec%0d_latency", i), 32'(cnt), 32'(vecs[i].lat));
         check($sformatf("vec%0d_hi", i), bus.HI, vecs[i].exp_hi);
         check($sformatf("vec%0d_lo", i), bus.LO, vecs[i].exp_lo);
         bus.ReadHILO = 2'd2;
         #1 check($sformatf("vec%0d_read_lo", i), bus.MDUResult, vecs[i].exp_lo);
         bus.ReadHILO = 2'd1;
         #1 check($sformatf("vec%0d_read_hi", i), bus.MDUResult, vecs[i].exp_hi);
         $display("vec %0d op=%0d rd1=%h rd2=%h -> hi=%h lo=%h busy_cycles=%0d",
                  i, vecs[i].op, vecs[i].rd1, vecs[i].rd2, bus.HI, bus.LO, cnt);
         tick();
      end
      bus.ReadHILO = 2'd0;
      #1 check("read_none_0", bus.MDUResult, 32'd0);
      bus.ReadHILO = 2'd3;
      #1 check("read_none_3", bus.MDUResult, 32'd0);

      // Reset in the middle of an operation (HI/LO currently 0 / 12).
      issue(4'd1, 32'd7, 32'd9);
      tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
      check("midrst_hi", bus.HI, 32'd0);
      check("midrst_lo", bus.LO, 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("postrst_busy", {31'd0, bus.Busy}, 32'd0);
      check("postrst_lo", bus.LO, 32'd0);
      $display("reset mid-op: busy=%0d hi=%h lo=%h", bus.Busy, bus.HI, bus.LO);

      // Req suppression of issue and MTLO, then MTLO/MTHI without Req.
      bus.Req = 1'b1;
      issue(4'd1, 32'd5, 32'd6);
      check("req_issue_busy", {31'd0, bus.Busy}, 32'd0);
      bus.MDUOP = 4'd6;
      bus.RD1   = 32'h1234;
      tick();
      check("req_mtlo_lo", bus.LO, 32'd0);
      bus.Req = 1'b0;
      tick();
      check("mtlo_lo", bus.LO, 32'h1234);
      bus.MDUOP = 4'd5;
      bus.RD1   = 32'h5678;
      tick();
      bus.MDUOP = 4'd0;
      check("mthi_hi", bus.HI, 32'h5678);
      check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
      tick();
      check("req_mult_lo_kept", bus.LO, 32'h1234);
      $display("req suppression: hi=%h lo=%h", bus.HI, bus.LO);

      // Req during RUN does not abort; a second Start and an MTHI while busy are ignored.
      issue(4'd2, 32'd3, 32'd5);
      cnt = 1;
      tick();
      cnt++;
      bus.Req = 1'b1;
      bus.Start = 1'b1;
      bus.MDUOP = 4'd4;
      bus.RD1 = 32'd100;
      bus.RD2 = 32'd7;
      tick();
      cnt++;
      bus.Req = 1'b0;
      tick();
      cnt++;
      bus.Start = 1'b0;
      bus.MDUOP = 4'd5;
      bus.RD1 = 32'hDEAD_BEEF;
      tick();
      bus.MDUOP = 4'd0;
      while (bus.Busy === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      check("busyissue_latency", 32'(cnt), 32'd5);
      check("busyissue_hi", bus.HI, 32'd0);
      check("busyissue_lo", bus.LO, 32'd15);
      $display("issue during busy: busy_cycles=%0d hi=%h lo=%h", cnt, bus.HI, bus.LO);

      // Back-to-back issue in the first idle cycle; completion-cycle read shows the old LO.
      issue(4'd1, 32'd2, 32'd3);
      wait_idle(cnt, lo_last);
      check("b2b_first_lo", bus.LO, 32'd6);
      hi_save = bus.HI;
      lo_save = bus.LO;
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      check("b2b_busy_rise", {31'd0, bus.Busy}, 32'd1);
      check("b2b_hold_hi", bus.HI, hi_save);
      wait_idle(cnt, lo_last);
      check("b2b_latency", 32'(cnt), 32'd5);
      check("b2b_last_busy_read", lo_last, lo_save);
      check("b2b_hi", bus.HI, 32'd1);
      check("b2b_lo", bus.LO, 32'hFFFF_FFFE);
      $display("back-to-back: busy_cycles=%0d last_busy_read=%h hi=%h lo=%h",
               cnt, lo_last, bus.HI, bus.LO);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Sits between the E pipeline register and the M pipeline register. Consumes StartE, MDUOPE, ReadHILOE, and the forwarded RD1E/RD2E operands. Produces MDUResultE and Busy for the hazard unit.
- Models multi-cycle MULT/DIV latency with an internal counter.
- Req-aware, so an instruction flushed by an exception never commits HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Req  in  1  exception/interrupt flush request from CP0; suppresses new issue in the same cycle
Start  in  1  StartE, valid issue strobe for MULT/MULTU/DIV/DIVU
MDUOP  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others none
ReadHILO  in  2  0 none, 1 read HI, 2 read LO, 3 none
RD1  in  32  forwarded rs operand
RD2  in  32  forwarded rt operand
Busy  out  1  registered; high while an operation is in flight
MDUResult  out  32  combinational HI/LO read data
HI  out  32  current HI (debug/test)
LO  out  32  current LO (debug/test)

Behaviour:
- **Reset (async, rst=1):** HI=0, LO=0, Busy=0, counter=0, pending result=0, op latch=none. Any in-flight operation is discarded.
- **Issue condition:** Start=1 & MDUOP in {1..4} & Busy=0 & Req=0.
  - At that edge, compute and latch the result into pending registers {hi_p, lo_p}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; set Busy=1.
- **Arithmetic:**
  - MULT: signed 32x32 -> 64; hi_p=[63:32], lo_p=[31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo_p=quotient truncated toward zero, hi_p=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divisor (RD2) == 0: no update; HI/LO keep their old values at completion.
- **States:** IDLE (Busy=0) and RUN (Busy=1).
  - RUN decrements the counter each edge.
  - At the edge where counter==1: HI<=hi_p, LO<=lo_p (unless divide-by-zero), Busy<=0, return to IDLE.
- **Timing:** with issue at cycle T, Busy is high for cycles T+1..T+N, where N is the latency. New HI/LO are visible from cycle T+N+1.
- **Start while Busy=1:** ignored. The hazard unit must stall on (Busy | Start); the block does not queue.
- **MTHI/MTLO** (MDUOP 5/6): when Req=0 and Busy=0, write RD1 into HI/LO at the next edge. No Busy, and independent of Start.
  - If MDUOP 5/6 arrives while Busy=1, it is ignored (the stall unit prevents this).
- **Req=1:** blocks all issue and MTHI/MTLO writes in that cycle. An operation already in RUN continues to completion, because it was committed by an older instruction.
- **Simultaneous completion and read:** MDUResult reflects the pre-edge HI/LO in the completion cycle. Reads are combinational from the HI/LO registers, with no bypass of pending values.
- **MDUResult:**
  - ReadHILO=1 -> HI
  - ReadHILO=2 -> LO
  - else 32'd0
- **Outputs and counter:** HI and LO are driven directly from the registers. The counter is 4 bits and never wraps below 0.

Test Plan:
1. **Reset mid-operation:** issue MULT 3x4, assert rst in cycle T+2 -> Busy=0, HI=0, LO=0 immediately, and they stay 0 after rst is released.
2. **MULT signed:** RD1=32'hFFFF_FFFE (-2), RD2=3 -> Busy high for exactly 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. With ReadHILO=2, MDUResult=32'hFFFF_FFFA.
3. **DIV signed / DIVU:**
   - DIV RD1=-7, RD2=2 -> after 10 Busy cycles, LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
   - DIVU 7/0 -> HI/LO unchanged.
4. **Req suppression:** Start=1, MDUOP=1, Req=1 -> Busy stays 0, HI/LO unchanged. MTLO RD1=32'h1234 with Req=1 -> LO unchanged; the same op with Req=0 -> LO=32'h1234 next cycle.
5. **Issue during Busy:** issue MULTU (5 cycles), then re-assert Start with DIVU at T+2 -> the second op is ignored. The final HI/LO match the MULTU result, and Busy drops after 5 cycles.
6. **Back-to-back:** issue MULTU 32'hFFFF_FFFF x 2 in the cycle after Busy falls -> Busy rises again at the next edge. Result HI=1, LO=32'hFFFF_FFFE.
